dpram_arbiter_2x: RTL and testbench
===================================

# dpram_arbiter_2x

Two-requester arbiter sharing one `dpram_1024x32` instance. It is placed between two client engines and the RAM macro. It arbitrates the RAM write port and read port independently, with a separate round-robin pointer for each port. It returns read data to the originating requester one cycle after grant. Both RAM ports are driven from the single arbiter clock, so `wclk` and `rclk` of the RAM are tied to `clk`.

## Interface
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 32, data width
- clk  input  1  single clock, also drives RAM wclk/rclk
- rst_n  input  1  reset, synchronous, active-low
- req_valid  input  2  per-requester request valid (bit i = requester i)
- req_we  input  2  per-requester op: 1 = write, 0 = read
- req_addr  input  2×ADDR_W  per-requester address
- req_wdata  input  2×DATA_W  per-requester write data
- req_ready  output  2  per-requester grant; request consumed when valid & ready
- rsp_valid  output  2  per-requester read-data valid, one-cycle pulse
- rsp_rdata  output  DATA_W  read data, shared bus, qualified by rsp_valid
- ram_wen  output  1  to RAM wen
- ram_waddr  output  ADDR_W  to RAM waddr
- ram_wdata  output  DATA_W  to RAM data_in
- ram_ren  output  1  to RAM ren
- ram_raddr  output  ADDR_W  to RAM raddr
- ram_rdata  input  DATA_W  from RAM d_out

## Operation
- **Write arbitration.** Write contenders are requesters with req_valid & req_we. Resolution uses write pointer wptr:
  - if only one contends, it wins;
  - if both contend, requester wptr wins;
  - after any write grant, wptr is set to the non-winner.
- **Read arbitration.** Same scheme for read contenders (req_valid & ~req_we), using rptr.
- **Independent ports.**
  - One write and one read may be granted in the same cycle, from the same or different requesters.
  - A requester holds only one request per cycle, so it receives at most one grant.
- **Combinational outputs.**
  - req_ready[i] = grant[i]. A requester may depend on ready combinationally, but valid must not depend on ready.
  - ram_wen/ram_waddr/ram_wdata are muxed from the write winner.
  - ram_ren/ram_raddr are muxed from the read winner.
  - ram_wen = 0 and ram_ren = 0 when there is no winner.
- **Read response.**
  - A 1-bit register rid captures the read winner, and rvld captures ram_ren.
  - The following cycle: rsp_valid[rid] = rvld, and rsp_rdata = ram_rdata.
  - There is no response backpressure; requesters must accept rsp_valid when it is asserted.
- **Same-address hazard.** If a write and a read to the same address are granted in one cycle, the read returns the old RAM contents, unless the bypass feature is enabled (see Configuration).
- **Reset (rst_n low at posedge).**
  - wptr = 0, rptr = 0, rvld = 0, rid = 0, and the bypass register is cleared.
  - While rst_n is low, req_ready = 0, ram_wen = 0 and ram_ren = 0.
- **Reset mid-operation.** A read granted in the cycle before reset takes effect produces no rsp_valid. RAM contents are not cleared.

## Timing
- Grant latency: 0 cycles; ready is in the same cycle as valid when the requester wins.
- Read latency: rsp_valid is 1 cycle after the accepting edge.
- Write: RAM is updated at the accepting edge.
- Sustained throughput: 1 write + 1 read per cycle in aggregate.
- Under continuous contention each requester wins every 2nd cycle per port, so the worst-case wait is 1 cycle.
- After reset release, the first contended cycle grants requester 0 on both ports.
- Output values during reset: rsp_valid = 00, rsp_rdata = 0, ram_wen = 0, ram_ren = 0, req_ready = 00.

## Configuration
- Macro: DPRAM_ARB_WR_BYPASS_EN.
- **Defined:**
  - On a same-cycle write+read grant with ram_waddr == ram_raddr, the arbiter registers ram_wdata and a bypass flag.
  - In the response cycle, rsp_rdata is the registered write data instead of ram_rdata.
  - This costs one extra DATA_W register plus an address comparator.
- **Undefined:** rsp_rdata is always ram_rdata, and the hazard returns old data.

## Structure
- Package `dpram_arb_pkg` holds:
  - ADDR_W/DATA_W default constants;
  - req_id_t (1-bit requester id);
  - an op encoding constant (OP_RD = 0, OP_WR = 1).
- Sub-module `rr_arb2` implements the 2-way round-robin. It has inputs req[1:0], a pointer register with synchronous active-low reset, an advance-on-grant rule, and outputs gnt[1:0] plus winner id. It is instantiated twice, once for the write port and once for the read port.
- The top level contains the RAM-side muxes, the response register, and the optional bypass.

## Test plan
- **Reset values.** Hold rst_n = 0 for 3 cycles with both requesters' req_valid = 11 → req_ready = 00, ram_wen = ram_ren = 0, rsp_valid = 00. Release reset with both writing → requester 0 is granted first.
- **Write/read round trip.** Req0 writes 0xDEADBEEF to address 0x005, then reads 0x005 → rsp_valid = 01 one cycle after the read grant, rsp_rdata = 0xDEADBEEF.
- **Read contention.** Both requesters read continuously for 6 cycles: req0 reads 0x010 and req1 reads 0x020, with both locations preloaded (0x010 = 0x11, 0x020 = 0x22) → grants alternate 0,1,0,1,0,1; responses alternate 0x11/0x22 to the matching rsp_valid bit.
- **Concurrent ports.** Req0 writes 0x3FF with 0xA5A5A5A5 while req1 reads 0x000 (holding 0x12345678) → both are granted in the same cycle; req1 gets 0x12345678.
- **Same-address hazard.** Address 0x0A0 holds 0x1; in one cycle req0 writes 0x2 to 0x0A0 and req1 reads 0x0A0 → rsp_rdata = 0x1 without DPRAM_ARB_WR_BYPASS_EN, 0x2 with it. A later read returns 0x2 in both builds.
- **Reset mid-operation.** Req1's read is granted and rst_n is asserted at the next edge → no rsp_valid; after release, wptr and rptr favour requester 0.

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// Shared constants and types for the two-requester RAM arbiter.
// Includes the op encoding and the requester-id helper used by the round-robin pointers.
package dpram_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    typedef logic req_id_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // With two requesters the pointer always moves to whoever did not just win.
    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/dpram_arbiter_2x_if.sv
// Requester-side bundle of dpram_arbiter_2x: per-requester request/grant plus read responses.
// Bit or element i of every vector belongs to requester i.
interface dpram_arbiter_2x_if
    import dpram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [1:0]             req_valid;
    logic [1:0]             req_we;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0]             req_ready;
    logic [1:0]             rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the pointer,
// and the pointer moves to the loser after every grant.
module rr_arb2
    import dpram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output req_id_t    winner
);

    req_id_t ptr;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        winner = ptr;
        gnt    = '0;
        if (req == 2'b01) begin
            winner = 1'b0;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end
        if (|req) begin
            gnt[winner] = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (|req) begin
            ptr <= other_req(winner);
        end
    end

endmodule

// File: rtl/dpram_arbiter_2x.sv
// Shares one dpram_1024x32 between two requesters, arbitrating write and read ports independently.
// Optional DPRAM_ARB_WR_BYPASS_EN forwards same-cycle write data to a colliding read.
module dpram_arbiter_2x
    import dpram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic              clk,
    input  logic              rst_n,
    dpram_arbiter_2x_if.slave bus,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_ren,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic [1:0]        wreq;
    logic [1:0]        rreq;
    logic [1:0]        wgnt;
    logic [1:0]        rgnt;
    req_id_t           wwin;
    req_id_t           rwin;
    req_id_t           rid;
    logic              rvld;
    logic [DATA_W-1:0] rsp_sel;

    // Requests are masked during reset so neither pointer moves and nothing is granted.
    always_comb begin
        wreq = '0;
        rreq = '0;
        for (int i = 0; i < 2; i++) begin
            wreq[i] = rst_n && bus.req_valid[i] && (bus.req_we[i] == OP_WR);
            rreq[i] = rst_n && bus.req_valid[i] && (bus.req_we[i] == OP_RD);
        end
    end

    rr_arb2 u_warb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (wreq),
        .gnt    (wgnt),
        .winner (wwin)
    );

    rr_arb2 u_rarb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (rreq),
        .gnt    (rgnt),
        .winner (rwin)
    );

    assign bus.req_ready = wgnt | rgnt;

    assign ram_wen   = |wgnt;
    assign ram_waddr = bus.req_addr[wwin];
    assign ram_wdata = bus.req_wdata[wwin];
    assign ram_ren   = |rgnt;
    assign ram_raddr = bus.req_addr[rwin];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvld <= 1'b0;
            rid  <= 1'b0;
        end else begin
            rvld <= ram_ren;
            rid  <= rwin;
        end
    end

`ifdef DPRAM_ARB_WR_BYPASS_EN
    logic              byp_flag;
    logic [DATA_W-1:0] byp_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byp_flag <= 1'b0;
            byp_data <= '0;
        end else begin
            byp_flag <= ram_wen && ram_ren && (ram_waddr == ram_raddr);
            byp_data <= ram_wdata;
        end
    end

    assign rsp_sel = byp_flag ? byp_data : ram_rdata;
`else
    assign rsp_sel = ram_rdata;
`endif

    // Responses are forced quiet while reset is held, which also drops a read granted just before it.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_rdata = '0;
        if (rst_n) begin
            bus.rsp_rdata = rsp_sel;
            if (rvld) begin
                bus.rsp_valid[rid] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dpram_arbiter_2x.sv
// Directed bench for dpram_arbiter_2x with a behavioural 1024x32 RAM (registered read, old data on collision).
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
module tb_dpram_arbiter_2x;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_wen;
    logic [9:0]  ram_waddr;
    logic [31:0] ram_wdata;
    logic        ram_ren;
    logic [9:0]  ram_raddr;
    logic [31:0] ram_rdata = '0;
    logic [31:0] mem [1024];

    int n_checks = 0;
    int n_errors = 0;

    dpram_arbiter_2x_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    dpram_arbiter_2x #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_wen   (ram_wen),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_ren   (ram_ren),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= mem[ram_raddr];
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [9:0] a0, input logic [31:0] d0,
                         input logic [9:0] a1, input logic [31:0] d1);
        bus.req_valid    = v;
        bus.req_we       = we;
        bus.req_addr[0]  = a0;
        bus.req_wdata[0] = d0;
        bus.req_addr[1]  = a1;
        bus.req_wdata[1] = d1;
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] v, input logic [31:0] d);
        check({tag, "_rsp_valid"}, bus.rsp_valid, v);
        if (v != 2'b00) check({tag, "_rsp_rdata"}, bus.rsp_rdata, d);
    endtask

    initial begin
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_rsp;
        logic [31:0] exp_dat;
        logic [31:0] hazard_dat;

        // Reset held for three edges with both requesters writing.
        rst_n = 1'b0;
        drive(2'b11, 2'b11, 10'h005, 32'hDEADBEEF, 10'h3FE, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("rst_ready", bus.req_ready, 2'b00);
            check("rst_wen", ram_wen, 1'b0);
            check("rst_ren", ram_ren, 1'b0);
            check("rst_rsp_valid", bus.rsp_valid, 2'b00);
            check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        end

        // C1: release with both writing; requester 0 wins.
        rst_n = 1'b1;
        #1;
        check("c1_ready", bus.req_ready, 2'b01);
        check("c1_wen", ram_wen, 1'b1);
        check("c1_waddr", ram_waddr, 10'h005);
        check("c1_wdata", ram_wdata, 32'hDEADBEEF);
        check("c1_ren", ram_ren, 1'b0);

        // C2: req0 reads back 0x005.
        @(negedge clk);
        drive(2'b01, 2'b00, 10'h005, 32'h0, 10'h000, 32'h0);
        #1;
        check("c2_ready", bus.req_ready, 2'b01);
        check("c2_ren", ram_ren, 1'b1);
        check("c2_raddr", ram_raddr, 10'h005);
        check("c2_wen", ram_wen, 1'b0);

        // C3: write contention, wptr now favours requester 1.
        @(negedge clk);
        drive(2'b11, 2'b11, 10'h010, 32'h11, 10'h020, 32'h22);
        #1;
        check_rsp("c3", 2'b01, 32'hDEADBEEF);
        check("c3_ready", bus.req_ready, 2'b10);
        check("c3_waddr", ram_waddr, 10'h020);

        // C4: req0 writes 0x010 while req1 reads 0x005 in the same cycle.
        @(negedge clk);
        drive(2'b11, 2'b01, 10'h010, 32'h11, 10'h005, 32'h0);
        #1;
        check_rsp("c4", 2'b00, 32'h0);
        check("c4_ready", bus.req_ready, 2'b11);
        check("c4_waddr", ram_waddr, 10'h010);
        check("c4_raddr", ram_raddr, 10'h005);

        // C5..C10: continuous read contention alternates 0,1,0,1,0,1.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(2'b11, 2'b00, 10'h010, 32'h0, 10'h020, 32'h0);
            #1;
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
            if (i == 0) begin
                exp_rsp = 2'b10;
                exp_dat = 32'hDEADBEEF;
            end else begin
                exp_rsp = (i % 2 == 0) ? 2'b10 : 2'b01;
                exp_dat = (i % 2 == 0) ? 32'h22 : 32'h11;
            end
            check("rc_ready", bus.req_ready, exp_gnt);
            check("rc_raddr", ram_raddr, (i % 2 == 0) ? 10'h010 : 10'h020);
            check_rsp("rc", exp_rsp, exp_dat);
        end

        // C11: preload 0x000.
        @(negedge clk);
        drive(2'b01, 2'b01, 10'h000, 32'h12345678, 10'h000, 32'h0);
        #1;
        check_rsp("c11", 2'b10, 32'h22);
        check("c11_ready", bus.req_ready, 2'b01);

        // C12: concurrent ports, req0 writes 0x3FF, req1 reads 0x000.
        @(negedge clk);
        drive(2'b11, 2'b01, 10'h3FF, 32'hA5A5A5A5, 10'h000, 32'h0);
        #1;
        check("c12_ready", bus.req_ready, 2'b11);
        check("c12_waddr", ram_waddr, 10'h3FF);
        check("c12_wdata", ram_wdata, 32'hA5A5A5A5);
        check("c12_raddr", ram_raddr, 10'h000);
        check_rsp("c12", 2'b00, 32'h0);

        // C13: preload 0x0A0 = 1.
        @(negedge clk);
        drive(2'b10, 2'b10, 10'h000, 32'h0, 10'h0A0, 32'h1);
        #1;
        check_rsp("c13", 2'b10, 32'h12345678);
        check("c13_ready", bus.req_ready, 2'b10);

        // C14: same-address write (req0) and read (req1).
        @(negedge clk);
        drive(2'b11, 2'b01, 10'h0A0, 32'h2, 10'h0A0, 32'h0);
        #1;
        check("c14_ready", bus.req_ready, 2'b11);

        // C15: hazard response; req1 re-reads 0x0A0.
        @(negedge clk);
        drive(2'b10, 2'b00, 10'h000, 32'h0, 10'h0A0, 32'h0);
        #1;
`ifdef DPRAM_ARB_WR_BYPASS_EN
        hazard_dat = 32'h2;
`else
        hazard_dat = 32'h1;
`endif
        check_rsp("c15_hazard", 2'b10, hazard_dat);
        check("c15_ready", bus.req_ready, 2'b10);

        // C16: later read sees the new value; req0 reads 0x3FF.
        @(negedge clk);
        drive(2'b01, 2'b00, 10'h3FF, 32'h0, 10'h000, 32'h0);
        #1;
        check_rsp("c16", 2'b10, 32'h2);
        check("c16_ready", bus.req_ready, 2'b01);

        // C17: req1 read granted, then reset asserted before the next edge.
        @(negedge clk);
        drive(2'b10, 2'b00, 10'h000, 32'h0, 10'h005, 32'h0);
        #1;
        check_rsp("c17", 2'b01, 32'hA5A5A5A5);
        check("c17_ready", bus.req_ready, 2'b10);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(2'b11, 2'b11, 10'h100, 32'h55, 10'h101, 32'h66);
        #1;
        check("mid_rst_rsp_valid", bus.rsp_valid, 2'b00);
        check("mid_rst_ready", bus.req_ready, 2'b00);
        check("mid_rst_wen", ram_wen, 1'b0);
        @(negedge clk); #1;
        check("mid_rst_rsp_valid2", bus.rsp_valid, 2'b00);

        // Release: both ports must favour requester 0 again.
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b11, 2'b11, 10'h100, 32'h55, 10'h101, 32'h66);
        #1;
        check("rel_w_ready", bus.req_ready, 2'b01);
        check("rel_waddr", ram_waddr, 10'h100);
        check("rel_rsp_valid", bus.rsp_valid, 2'b00);

        @(negedge clk);
        drive(2'b11, 2'b00, 10'h100, 32'h0, 10'h101, 32'h0);
        #1;
        check("rel_r_ready", bus.req_ready, 2'b01);
        check("rel_raddr", ram_raddr, 10'h100);

        @(negedge clk);
        drive(2'b00, 2'b00, 10'h000, 32'h0, 10'h000, 32'h0);
        #1;
        check_rsp("rel", 2'b01, 32'h55);
        check("idle_wen", ram_wen, 1'b0);
        check("idle_ren", ram_ren, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
